slave_rx: RTL
=============

// Module: slave_rx
// PURPOSE
//  Receive end of the dual-line serial link driven by `master`. Samples sclk,
//  DataLine0/1 and CS in the clk domain and rebuilds the 71-bit word
//  {len[6:0], payload[63:0]} that the transmitter was loaded with.
//  Sits on the far side of the link and hands complete frames to downstream
//  logic with a one-cycle valid strobe and an error strobe.
// PARAMETERS
//  SYNC_STAGES  2   flops per input synchronizer (sclk, CS, DataLine0/1), min 2
//  LEN_W        7   width of the length field
//  MAX_LEN      64  largest legal payload length in bits
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rstn        in   1   asynchronous active-low reset
//  sclk        in   1   serial clock from master, idle low, asynchronous to clk
//  DataLine0   in   1   even bit of each pair (bit 2k)
//  DataLine1   in   1   odd bit of each pair (bit 2k+1)
//  CS          in   1   frame select, active low
//  data_out    out  71  {len, payload}; payload right-aligned and zero-extended
//  data_valid  out  1   one-clk pulse when data_out is updated with a good frame
//  frame_err   out  1   one-clk pulse when a frame is rejected
// BEHAVIOUR
//  - Reset: data_out=0, data_valid=0, frame_err=0, state=IDLE, counters=0.
//  - All four inputs pass through SYNC_STAGES flops, so they stay mutually aligned.
//    sclk edge = rising edge of synchronized sclk (sync_sclk & ~sclk_d).
//  - Requirement: f_sclk <= f_clk/4; each sclk level lasts >= 2 clk cycles.
//  - Frame on wire: CS falls, then 8-bit header {1'b0, len[6:0]}, then len payload
//    bits, MSB pair first. Each sclk edge carries 2 bits: DataLine1 = higher bit,
//    DataLine0 = lower bit. Header = 4 edges; payload = len/2 edges. Then CS rises.
//  - Shift: on each sclk edge, sr <= {sr[..], DataLine1, DataLine0}; pair_cnt++.
//  - FSM:
//    IDLE   : on synchronized CS falling edge -> HEADER, pair_cnt=0, sr=0.
//             CS already low at reset release: stay in IDLE until CS goes high and
//             falls again.
//    HEADER : after 4th edge, latch len. len==0, len odd, len>MAX_LEN, or header
//             bit7==1 -> ERR. Otherwise -> PAYLOAD.
//    PAYLOAD: after edge len/2 -> DONE.
//    DONE   : waiting for CS to rise. Another sclk edge arrives -> ERR.
//             When CS rises: data_out <= {len, 64'(payload)} and data_valid=1 for
//             1 clk -> IDLE.
//    ERR    : ignore sclk edges; on CS rise pulse frame_err for 1 clk -> IDLE.
//  - CS rises in HEADER or PAYLOAD (short frame): frame_err pulse, -> IDLE.
//  - data_out keeps the last good frame; rejected frames never change it.
//  - Latency: data_valid and frame_err assert on the clk edge after the
//    synchronized CS rising edge is detected (SYNC_STAGES+1 clks after CS pin rises).
//  - An sclk edge and a CS rise detected in the same clk: the edge is processed
//    first, then the CS rise.
//  - Asynchronous reset mid-frame drops the partial frame. No valid or err pulse.
// TESTING
//  1 len=8, payload 8'h5A -> data_valid x1, data_out={7'd8,56'd0,8'h5A}, err=0
//  2 len=64, 64'hFEDC_BA98_7654_3210 -> data_out={7'd64,64'hFEDC_BA98_7654_3210}
//  3 back-to-back len=16 16'hAC69 then len=48 48'h1234_5678_ABCD -> 2 valid
//    pulses, matching data_out each time
//  4 CS rises after 10 of 16 payload pairs (len=32) -> frame_err x1, data_valid=0,
//    data_out holds previous value
//  5 header len=7, then len=72 -> frame_err x1 each, no data_valid
//  6 rstn low for 3 clks mid-payload, CS held low -> all outputs 0; next full
//    frame after CS goes high accepted with data_valid x1

Source files
------------

// File: rtl/slave_rx.sv
`default_nettype none
// ============================================================================
//  Module  : slave_rx
//  Brief   : Dual-line serial frame receiver. Rebuilds {len, payload} frames.
//  Rev     : 1.0  initial release
// ============================================================================
module slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = 7,
    parameter int MAX_LEN     = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sclk,
    input  logic                     DataLine0,
    input  logic                     DataLine1,
    input  logic                     CS,
    output logic [LEN_W+MAX_LEN-1:0] data_out,
    output logic                     data_valid,
    output logic                     frame_err
);
    localparam int CNT_W     = LEN_W - 1;
    localparam int HDR_PAIRS = (LEN_W + 1) / 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t state, state_next, mid;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, d0_sync, d1_sync;
    logic                   sclk_d, cs_d;
    logic                   s_sclk, s_cs, s_d0, s_d1;
    logic                   sclk_rise, cs_rise, cs_fall;
    logic [MAX_LEN-1:0]     sr, sr_next;
    logic [CNT_W-1:0]       pair_cnt, cnt_next;
    logic [LEN_W-1:0]       len_q, len_next;
    logic [LEN_W:0]         hdr;
    logic                   hdr_bad;
    logic                   pulse_valid, pulse_err;

    // CS chain resets low so a CS already asserted at reset release is not seen as a fall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            d0_sync   <= '0;
            d1_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            d0_sync   <= {d0_sync[SYNC_STAGES-2:0], DataLine0};
            d1_sync   <= {d1_sync[SYNC_STAGES-2:0], DataLine1};
            sclk_d    <= s_sclk;
            cs_d      <= s_cs;
        end
    end

    assign s_sclk    = sclk_sync[SYNC_STAGES-1];
    assign s_cs      = cs_sync[SYNC_STAGES-1];
    assign s_d0      = d0_sync[SYNC_STAGES-1];
    assign s_d1      = d1_sync[SYNC_STAGES-1];
    assign sclk_rise = s_sclk & ~sclk_d;
    assign cs_rise   = s_cs & ~cs_d;
    assign cs_fall   = ~s_cs & cs_d;

    assign hdr     = {sr[LEN_W-2:0], s_d1, s_d0};
    assign hdr_bad = hdr[LEN_W] | (hdr[LEN_W-1:0] == '0) | hdr[0]
                   | (hdr[LEN_W-1:0] > LEN_W'(MAX_LEN));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            sr         <= '0;
            pair_cnt   <= '0;
            len_q      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            sr         <= sr_next;
            pair_cnt   <= cnt_next;
            len_q      <= len_next;
            data_valid <= pulse_valid;
            frame_err  <= pulse_err;
            if (pulse_valid) begin
                data_out <= {len_q, sr_next};
            end
        end
    end

    // An sclk edge is applied first (giving mid), then a CS rise acts on mid
    always_comb begin
        mid         = state;
        state_next  = state;
        sr_next     = sr;
        cnt_next    = pair_cnt;
        len_next    = len_q;
        pulse_valid = 1'b0;
        pulse_err   = 1'b0;

        if (sclk_rise) begin
            case (state)
                HEADER: begin
                    sr_next  = {sr[MAX_LEN-3:0], s_d1, s_d0};
                    cnt_next = pair_cnt + CNT_W'(1);
                    if (pair_cnt == CNT_W'(HDR_PAIRS - 1)) begin
                        len_next = hdr[LEN_W-1:0];
                        cnt_next = '0;
                        sr_next  = '0;
                        mid      = hdr_bad ? ERR : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    sr_next  = {sr[MAX_LEN-3:0], s_d1, s_d0};
                    cnt_next = pair_cnt + CNT_W'(1);
                    if (cnt_next == len_q[LEN_W-1:1]) begin
                        mid = DONE;
                    end
                end
                DONE:    mid = ERR;
                default: mid = state;
            endcase
        end

        state_next = mid;
        case (mid)
            IDLE: begin
                if (cs_fall) begin
                    state_next = HEADER;
                    sr_next    = '0;
                    cnt_next   = '0;
                end
            end
            HEADER, PAYLOAD, ERR: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    pulse_err  = 1'b1;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_next  = IDLE;
                    pulse_valid = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire
